// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and timing helper functions.
// Optional parity build: define UART_TX_PARITY_EN to add the PARITY state.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;
`endif

  // Clock cycles per line bit, truncated toward zero.
  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Width able to hold 0..max_count-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count <= 1) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Emits a one-cycle tick on the last cycle of each bit period; i_clear holds it at zero.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = 5208,
  parameter int unsigned CNT_W          = cnt_width(CYCLES_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CYCLES_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  assign o_tick = !i_clear && (r_count == LP_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one frame per accepted byte, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to append an even-parity bit after the payload.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    uart_txd,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_busy
);

  localparam int unsigned      CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned      BIT_W          = cnt_width(PAYLOAD_BITS);
  localparam logic [BIT_W-1:0] LP_LAST_DATA   = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0] LP_LAST_STOP   = BIT_W'(STOP_BITS - 1);

  uart_state_t             r_state;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic                    r_txd;
  logic                    r_busy;
  logic                    w_tick;
  logic                    w_baud_clear;
`ifdef UART_TX_PARITY_EN
  logic                    r_parity;
`endif

  assign w_baud_clear = (r_state == IDLE);
  assign uart_txd     = r_txd;
  assign uart_tx_busy = r_busy;

  uart_baud_tick #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_baud_clear),
    .o_tick (w_tick)
  );

  // The next line level is loaded together with each state change so the
  // line comes straight from a flop and switches on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_txd     <= 1'b1;
          r_bit_cnt <= '0;
          if (uart_tx_en) begin
            r_shift  <= uart_tx_data;
            r_state  <= START;
            r_txd    <= 1'b0;
            r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^uart_tx_data;
`endif
          end
        end

        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_txd   <= r_shift[0];
          end
        end

        DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == LP_LAST_DATA) begin
              r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= PARITY;
              r_txd     <= r_parity;
`else
              r_state   <= STOP;
              r_txd     <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= r_shift >> 1;
              r_txd     <= r_shift[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
            r_txd   <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (w_tick) begin
            if (r_bit_cnt == LP_LAST_STOP) begin
              r_state   <= IDLE;
              r_busy    <= 1'b0;
              r_txd     <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with a short bit period; the expected line is
// built per frame as a list of bit levels and compared on every clock cycle.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int unsigned CLK_HZ       = 160;
  localparam int unsigned BIT_RATE     = 10;
  localparam int unsigned PAYLOAD_BITS = 8;
  localparam int unsigned STOP_BITS    = 1;
  localparam int          C            = CLK_HZ / BIT_RATE;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    uart_txd;
  logic                    uart_tx_en;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;
  logic                    uart_tx_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .BIT_RATE    (BIT_RATE),
    .CLK_HZ      (CLK_HZ),
    .PAYLOAD_BITS(PAYLOAD_BITS),
    .STOP_BITS   (STOP_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_txd    (uart_txd),
    .uart_tx_en  (uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Called at a negedge with the transmitter idle. Sends d and checks the line
  // every cycle against the bit list of the frame. hold_en keeps the request
  // high afterwards; noisy scribbles data and pulses en while busy; abort_at>=0
  // hits reset at that frame cycle and returns once reset is released.
  task automatic run_frame(input logic [PAYLOAD_BITS-1:0] d, input bit hold_en,
                           input bit noisy, input int abort_at);
    bit q[$];
    int frame;
    q.push_back(1'b0);
    for (int i = 0; i < PAYLOAD_BITS; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    q.push_back(^d);
`endif
    for (int i = 0; i < STOP_BITS; i++) q.push_back(1'b1);
    frame = q.size() * C;

    uart_tx_en   = 1'b1;
    uart_tx_data = d;
    @(negedge clk);
    if (!hold_en) uart_tx_en = 1'b0;

    for (int cyc = 0; cyc < frame; cyc++) begin
      check("line", uart_txd, q[cyc / C]);
      check("busy_high", uart_tx_busy, 1);
      if (cyc == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_txd", uart_txd, 1);
        check("abort_busy", uart_tx_busy, 0);
        uart_tx_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (noisy) begin
        uart_tx_data = PAYLOAD_BITS'($urandom);
        if (!hold_en) uart_tx_en = ($urandom_range(0, 3) == 0);
      end
      if (cyc == frame - 1 && !hold_en) uart_tx_en = 1'b1;
      @(negedge clk);
    end

    if (!hold_en) uart_tx_en = 1'b0;
    check("end_busy_low", uart_tx_busy, 0);
    check("end_idle_high", uart_txd, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_txd", uart_txd, 1);
      check("idle_busy", uart_tx_busy, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [PAYLOAD_BITS-1:0] load_bytes [4];
    logic [PAYLOAD_BITS-1:0] rd;
    load_bytes[0] = 8'h13;
    load_bytes[1] = 8'h01;
    load_bytes[2] = 8'h01;
    load_bytes[3] = 8'hfd;

    rst          = 1'b1;
    uart_tx_en   = 1'b0;
    uart_tx_data = '0;
    #2000;
    check("reset_txd", uart_txd, 1);
    check("reset_busy", uart_tx_busy, 0);
    #2000;
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(1000);

    run_frame(8'h55, 1'b0, 1'b0, -1);
    idle_cycles(3);

    foreach (load_bytes[i]) run_frame(load_bytes[i], 1'b0, 1'b0, -1);
    idle_cycles(2);

    run_frame(8'hA3, 1'b0, 1'b1, -1);
    idle_cycles(2);

    run_frame(8'hFF, 1'b1, 1'b0, -1);
    run_frame(8'h00, 1'b0, 1'b0, -1);
    idle_cycles(2);

    run_frame(8'h00, 1'b0, 1'b0, 5 * C + 10);
    idle_cycles(3);
    run_frame(8'h0F, 1'b0, 1'b0, -1);
    idle_cycles(2);

    run_frame(8'h07, 1'b0, 1'b0, -1);

    for (int n = 0; n < 20; n++) begin
      rd = PAYLOAD_BITS'($urandom);
      run_frame(rd, ($urandom_range(0, 1) == 1), 1'b1, -1);
    end
    uart_tx_en = 1'b0;
    @(negedge clk);
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
